decoder_nx_seq: RTL
===================

Name: decoder_nx_seq

Overview:
- Parametrised, registered successor to the fixed 3-to-8 decoder: binary code in, IN_W-to-OUT_W pattern out, with a valid/ready handshake on both sides.
- Adds three behaviours the fixed decoder lacks: a thermometer output mode, a self-timed scan mode that steps through every output (row/digit strobing), and out-of-range code detection.
- Sits between control logic and one-hot select consumers such as mux selects, row drivers and chip selects.

Parameters:
- IN_W, 3, code width; legal range 1..8.
- OUT_W, 8, number of output lines; must satisfy 2 <= OUT_W <= 2**IN_W.
- ACTIVE_LOW, 0, when 1 every data_out bit is inverted (inactive level = 1).
- SCAN_DIV, 4, clock cycles per scan step; must be >= 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- enable  in  1  block enable; low forces outputs inactive and stalls all activity.
- mode  in  2  0 = ONEHOT, 1 = THERMO, 2 = SCAN, 3 = reserved.
- data_in  in  IN_W  binary code.
- in_valid  in  1  data_in is valid.
- in_ready  out  1  block accepts data_in this cycle.
- data_out  out  OUT_W  registered decoded pattern.
- out_valid  out  1  data_out holds an unconsumed result.
- out_ready  in  1  downstream consumes data_out.
- index_out  out  IN_W  code or scan index that produced data_out.
- code_err  out  1  registered; set with a result whose code was >= OUT_W.
- scan_wrap  out  1  one-cycle pulse when scan index OUT_W-1 is loaded.

Behaviour:
- Reset (rst_n = 0 at a clk edge) produces:
  - data_out = all inactive (0, or all ones if ACTIVE_LOW);
  - out_valid, code_err, scan_wrap = 0;
  - index_out = 0;
  - scan index and divider = 0.
- Reset overrides everything, including a handshake or scan step in progress; the result in flight is dropped.
- Output slot is free when out_valid = 0 or out_ready = 1. A load happens only at an edge where the slot is free.
- in_ready = enable and (mode == 0 or mode == 1) and slot free. This is combinational, with no dependency on in_valid.
- Input transfer occurs when in_valid and in_ready are both high at a clk edge. The result is valid at the next edge (1-cycle latency).
- Full throughput: one transfer per cycle while out_ready stays high.
- Pattern rules for code k (before ACTIVE_LOW inversion):
  - ONEHOT: bit k = 1, all other bits 0.
  - THERMO: bits 0..k = 1, rest 0.
  - Code k >= OUT_W: pattern is all zero, code_err = 1, out_valid = 1 (the result is still delivered), index_out = k.
  - Otherwise code_err = 0 and index_out = k.
- When out_valid = 1 and out_ready = 0: data_out, index_out and code_err are held stable. No load occurs.
- When out_valid = 1, out_ready = 1 and there is no new load: out_valid falls at the next edge. data_out holds its last value.
- SCAN mode:
  - in_ready = 0.
  - The divider counts 0..SCAN_DIV-1 while enable = 1.
  - At terminal count with the slot free: load the ONEHOT pattern of the scan index, set out_valid = 1 and index_out = index, advance the index (OUT_W-1 wraps to 0), and reset the divider.
  - At terminal count with the slot not free: the divider holds at terminal count and the index does not advance (backpressure stalls the scan, with no skipped lines).
  - scan_wrap is asserted for exactly the cycle after index OUT_W-1 is loaded.
  - With SCAN_DIV = 1 a line is loaded every free cycle.
- Entering SCAN from any other mode (mode registered internally, change detected) clears the scan index and divider. The first loaded line is 0, after SCAN_DIV cycles.
- Mode changes never corrupt a result already held: a pending out_valid result stays until consumed.
- Mode 3: in_ready = 0, no loads. The divider and index hold. Pending output drains normally.
- enable = 0 at an edge produces:
  - data_out = inactive, out_valid = 0, code_err = 0, scan_wrap = 0; any pending result is discarded;
  - divider and scan index hold their values;
  - in_ready = 0 combinationally.
- Re-enabling resumes the scan from the held index.
- ACTIVE_LOW inverts data_out only. out_valid, code_err and index_out are unaffected.

Test Plan:
- Reset/enable: rst_n = 0 for 2 cycles with enable = 1 and in_valid = 1 -> data_out = 00000000, out_valid = 0. Then enable = 0 with in_valid = 1 -> in_ready = 0 and data_out stays 00000000.
- ONEHOT streaming (IN_W = 3, OUT_W = 8): codes 0, 1, 2, 3, 4, 5, 6, 7 back-to-back with out_ready = 1 -> data_out = 00000001 ... 10000000, each one cycle after acceptance, out_valid continuously high, no bubbles.
- Backpressure: code 5 accepted, then out_ready = 0 for 3 cycles with code 2 offered -> in_ready = 0 and data_out held at 00100000. Release out_ready -> 00000100 appears the next cycle. No loss, no duplicate.
- THERMO plus out-of-range (OUT_W = 6): code 3 -> 001111, code_err = 0. Code 7 -> 000000, code_err = 1, index_out = 7.
- SCAN (SCAN_DIV = 2, OUT_W = 8, out_ready = 1): after entering mode 2, line 0 appears after 2 cycles, then every 2 cycles 00000001 -> ... -> 10000000 -> 00000001. scan_wrap pulses once per 16 cycles. Holding out_ready = 0 mid-scan freezes the index; the next line appears after release.
- ACTIVE_LOW = 1, mid-operation reset: code 2 -> 11111011. Assert rst_n = 0 during a SCAN stall -> data_out = 11111111, out_valid = 0, next scan restarts at line 0.

Source files
------------

// File: rtl/decoder_nx_seq.sv
// ---------------------------------------------------------------------------
// decoder_nx_seq
//
// Parametrised, registered binary-to-select decoder with valid/ready
// handshakes on both sides. It replaces the fixed 3-to-8 decoder and adds
// three behaviours:
//   - a thermometer output mode,
//   - a self-timed scan mode that strobes every output line in turn,
//   - detection of codes that have no output line (code >= OUT_W).
//
// Parameters
//   IN_W       code width (1..8)
//   OUT_W      number of output lines (2 .. 2**IN_W)
//   ACTIVE_LOW 1 inverts every data_out bit (inactive level = 1)
//   SCAN_DIV   clock cycles per scan step (>= 1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   enable     block enable; low forces outputs inactive and stalls activity
//   mode       0 = ONEHOT, 1 = THERMO, 2 = SCAN, 3 = reserved
//   data_in    binary code
//   in_valid   data_in is valid
//   in_ready   block accepts data_in this cycle (combinational)
//   data_out   registered decoded pattern
//   out_valid  data_out holds an unconsumed result
//   out_ready  downstream consumes data_out
//   index_out  code or scan index that produced data_out
//   code_err   registered; set with a result whose code was >= OUT_W
//   scan_wrap  one-cycle pulse after scan index OUT_W-1 is loaded
// ---------------------------------------------------------------------------
module decoder_nx_seq #(
  parameter int IN_W       = 3,
  parameter int OUT_W      = 8,
  parameter int ACTIVE_LOW = 0,
  parameter int SCAN_DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [IN_W-1:0]  data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IN_W-1:0]  index_out,
  output logic             code_err,
  output logic             scan_wrap
);

  // A one-cycle divider still needs a 1-bit register; it simply never
  // leaves zero, so every free cycle is a terminal count.
  localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IN_W-1:0]  IDX_LAST = IN_W'(OUT_W - 1);

  // XOR mask applied to every raw pattern; also the reset/disabled level.
  localparam logic [OUT_W-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}}
                                                            : {OUT_W{1'b0}};

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'd0,
    MODE_THERMO = 2'd1,
    MODE_SCAN   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  mode_e            mode_cur;
  mode_e            mode_q;
  logic [DIV_W-1:0] div_q;
  logic [IN_W-1:0]  scan_idx_q;

  logic [OUT_W-1:0] data_q;
  logic             valid_q;
  logic [IN_W-1:0]  index_q;
  logic             err_q;
  logic             wrap_q;

  logic slot_free;
  logic in_load;
  logic scan_entry;
  logic scan_tc;
  logic scan_load;

  // True when the code addresses no output line.
  function automatic logic code_out_of_range(input logic [IN_W-1:0] code);
    return int'(code) >= OUT_W;
  endfunction

  // Raw (active-high) pattern for a code; out-of-range codes give all zero,
  // including in thermometer mode where the fill would otherwise saturate.
  function automatic logic [OUT_W-1:0] decode_pattern(input logic [IN_W-1:0] code,
                                                      input logic            thermo);
    logic [OUT_W-1:0] pat;
    pat = '0;
    if (!code_out_of_range(code)) begin
      for (int i = 0; i < OUT_W; i++) begin
        pat[i] = thermo ? (i <= int'(code)) : (i == int'(code));
      end
    end
    return pat;
  endfunction

  assign mode_cur = mode_e'(mode);

  // The output slot can take a new result if it is empty or being drained
  // in this same cycle.
  assign slot_free = !valid_q || out_ready;

  assign in_ready = enable && (mode_cur == MODE_ONEHOT || mode_cur == MODE_THERMO)
                    && slot_free;
  assign in_load  = in_valid && in_ready;

  // The registered mode lets a fresh entry into SCAN restart from line 0;
  // the entry cycle itself only clears, it never loads.
  assign scan_entry = (mode_cur == MODE_SCAN) && (mode_q != MODE_SCAN);
  assign scan_tc    = (div_q == DIV_LAST);
  assign scan_load  = enable && (mode_cur == MODE_SCAN) && !scan_entry
                      && scan_tc && slot_free;

  // Scan divider and line index. While disabled nothing moves, mode_q
  // included, so re-enabling in SCAN resumes from the held line. A terminal
  // count that meets a full slot parks the divider there so no line is
  // skipped under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q     <= MODE_ONEHOT;
      div_q      <= '0;
      scan_idx_q <= '0;
    end else if (enable) begin
      mode_q <= mode_cur;
      if (mode_cur == MODE_SCAN) begin
        if (scan_entry) begin
          div_q      <= '0;
          scan_idx_q <= '0;
        end else if (scan_tc) begin
          if (slot_free) begin
            div_q      <= '0;
            scan_idx_q <= (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IN_W'(1);
          end
        end else begin
          div_q <= div_q + DIV_W'(1);
        end
      end
    end
  end

  // Output register. Disable discards any pending result; a drain without
  // a new load only drops valid and keeps the last pattern visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= INACTIVE;
      valid_q <= 1'b0;
      index_q <= '0;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (!enable) begin
      data_q  <= INACTIVE;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (in_load) begin
        data_q  <= decode_pattern(data_in, mode_cur == MODE_THERMO) ^ INACTIVE;
        valid_q <= 1'b1;
        index_q <= data_in;
        err_q   <= code_out_of_range(data_in);
      end else if (scan_load) begin
        data_q  <= decode_pattern(scan_idx_q, 1'b0) ^ INACTIVE;
        valid_q <= 1'b1;
        index_q <= scan_idx_q;
        err_q   <= 1'b0;
        wrap_q  <= (scan_idx_q == IDX_LAST);
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign index_out = index_q;
  assign code_err  = err_q;
  assign scan_wrap = wrap_q;

endmodule
